// File: rtl/dram_responder.sv
// dram_responder: target side of the MCU external-DRAM request port.
// Backs word requests with an on-chip array and emulates SDRAM-like timing:
// fixed per-type access latency plus periodic refresh stalls taken only from IDLE.
module dram_responder #(
  parameter int ADDR_BITS      = 24,
  parameter int XLEN           = 32,
  parameter int DEPTH_BITS     = 12,
  parameter int READ_LATENCY   = 4,
  parameter int WRITE_LATENCY  = 2,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] dram_mem_addr,
  input  logic                 dram_mem_read_en,
  input  logic                 dram_mem_write_en,
  input  logic [XLEN/8-1:0]    dram_mem_byte_enable,
  input  logic [XLEN-1:0]      dram_mem_write_data,
  output logic                 dram_ack,
  output logic [XLEN-1:0]      dram_mem_read_data,
  output logic                 busy,
  output logic                 refresh_active
);
  localparam int BE_W    = XLEN / 8;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int LCW     = $clog2(MAX_LAT) + 1;
  localparam int RCW     = $clog2(REFRESH_PERIOD) + 1;
  localparam int FCW     = $clog2(REFRESH_CYCLES) + 1;

  // WAIT is entered with LATENCY-2 so ACK lands exactly LATENCY cycles after the sample
  localparam logic [LCW-1:0] RD_LOAD = LCW'(READ_LATENCY - 2);
  localparam logic [LCW-1:0] WR_LOAD = LCW'(WRITE_LATENCY - 2);
  localparam logic [RCW-1:0] RC_LAST = RCW'(REFRESH_PERIOD - 1);
  localparam logic [FCW-1:0] RF_LOAD = FCW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFRESH, S_WAIT, S_ACK} state_t;

  state_t                  state_q, state_d;
  logic [LCW-1:0]          lat_cnt_q, lat_cnt_d;
  logic [FCW-1:0]          rfc_cnt_q, rfc_cnt_d;
  logic [RCW-1:0]          ref_cnt_q, ref_cnt_d;
  logic                    ref_pend_q, ref_pend_d;
  logic                    req_vld_q, req_vld_d;
  logic                    req_wr_q, req_wr_d;
  logic [DEPTH_BITS-1:0]   req_addr_q, req_addr_d;
  logic [BE_W-1:0]         req_be_q, req_be_d;
  logic [XLEN-1:0]         req_data_q, req_data_d;
  logic [XLEN-1:0]         rdata_q, rdata_d;
  logic                    mem_we, ref_wrap, req_in, wr_sel;
  state_t                  go_state;
  logic [LCW-1:0]          go_cnt;

  logic [XLEN-1:0]         mem [2**DEPTH_BITS];

  // address bits above the array depth alias; intentionally unused
  logic unused_addr_hi;
  assign unused_addr_hi = ^dram_mem_addr[ADDR_BITS-1:DEPTH_BITS];

  assign dram_ack           = (state_q == S_ACK);
  assign busy               = (state_q != S_IDLE);
  assign refresh_active     = (state_q == S_REFRESH);
  assign dram_mem_read_data = rdata_q;

  // next state, counters, request latch, refresh tracking and read-data capture
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rfc_cnt_d  = rfc_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    req_vld_d  = req_vld_q;
    req_wr_d   = req_wr_q;
    req_addr_d = req_addr_q;
    req_be_d   = req_be_q;
    req_data_d = req_data_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    ref_wrap   = 1'b0;
    req_in     = dram_mem_read_en | dram_mem_write_en;
    // the access type deciding latency is the live one in IDLE, the latched one after refresh
    wr_sel     = (state_q == S_IDLE) ? dram_mem_write_en : req_wr_q;
    go_state   = (wr_sel ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1)) ? S_ACK : S_WAIT;
    go_cnt     = wr_sel ? WR_LOAD : RD_LOAD;

    if (REFRESH_PERIOD != 0) begin
      if (ref_cnt_q == RC_LAST) begin
        ref_cnt_d = '0;
        ref_wrap  = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + RCW'(1);
      end
    end
    if (ref_wrap) ref_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_in) begin
          req_vld_d  = 1'b1;
          req_wr_d   = dram_mem_write_en;   // write wins when both are raised
          req_addr_d = dram_mem_addr[DEPTH_BITS-1:0];
          req_be_d   = dram_mem_byte_enable;
          req_data_d = dram_mem_write_data;
        end
        if (ref_pend_q) begin
          state_d   = S_REFRESH;
          rfc_cnt_d = RF_LOAD;
        end else if (req_in) begin
          state_d   = go_state;
          lat_cnt_d = go_cnt;
        end
      end
      S_REFRESH: begin
        if (rfc_cnt_q == '0) begin
          if (!ref_wrap) ref_pend_d = 1'b0;
          if (req_vld_q) begin
            state_d   = go_state;
            lat_cnt_d = go_cnt;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rfc_cnt_d = rfc_cnt_q - FCW'(1);
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) state_d = S_ACK;
        else                 lat_cnt_d = lat_cnt_q - LCW'(1);
      end
      S_ACK: begin
        state_d   = S_IDLE;
        req_vld_d = 1'b0;
        mem_we    = req_wr_q;
      end
      default: state_d = S_IDLE;
    endcase

    // read data is captured on the edge into ACK so it appears with the ack pulse
    if (state_d == S_ACK && !req_wr_d) rdata_d = mem[req_addr_d];

    if (sync_reset) begin
      state_d    = S_IDLE;
      lat_cnt_d  = '0;
      rfc_cnt_d  = '0;
      ref_cnt_d  = '0;
      ref_pend_d = 1'b0;
      req_vld_d  = 1'b0;
      req_wr_d   = 1'b0;
      req_addr_d = '0;
      req_be_d   = '0;
      req_data_d = '0;
      rdata_d    = '0;
      mem_we     = 1'b0;
    end
  end

  // control and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      rfc_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      req_vld_q  <= 1'b0;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_be_q   <= '0;
      req_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rfc_cnt_q  <= rfc_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      req_vld_q  <= req_vld_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_be_q   <= req_be_d;
      req_data_q <= req_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // backing array: byte-lane write at the ack edge, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be_q[i]) mem[req_addr_q][8*i +: 8] <= req_data_q[8*i +: 8];
      end
    end
  end
endmodule
